// File: rtl/stream_mux_pkg.sv
// Shared constants and helpers for the N-channel stream multiplexer.
package stream_mux_pkg;

  localparam logic MODE_SEL = 1'b0;  // sel port picks the channel
  localparam logic MODE_RR  = 1'b1;  // internal round-robin arbitration

  // Low bit index of channel ch inside a packed bus of width-bit lanes.
  function automatic int unsigned slice_lo(input int unsigned ch, input int unsigned width);
    return ch * width;
  endfunction

endpackage

// File: rtl/rr_arbiter_nch.sv
// Combinational rotate-priority search: first requester at or after ptr, wrapping.
module rr_arbiter_nch
  import stream_mux_pkg::*;
#(
  parameter  int NUM_CH = 4,
  localparam int SEL_W  = $clog2(NUM_CH)
) (
  input  logic [NUM_CH-1:0] req,
  input  logic [SEL_W-1:0]  ptr,
  output logic              gnt_valid,
  output logic [SEL_W-1:0]  gnt_idx
);

  // Scan offsets 0..NUM_CH-1 from ptr; the first hit wins.
  always_comb begin
    int unsigned pos;
    gnt_valid = 1'b0;
    gnt_idx   = '0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      pos = (32'(ptr) + i) % NUM_CH;
      if (!gnt_valid && req[SEL_W'(pos)]) begin
        gnt_valid = 1'b1;
        gnt_idx   = SEL_W'(pos);
      end
    end
  end

endmodule

// File: rtl/stream_mux_nch.sv
// N-channel valid/ready stream mux with external-select or round-robin
// channel choice and a single registered output stage.
module stream_mux_nch
  import stream_mux_pkg::*;
#(
  parameter  int NUM_CH = 4,
  parameter  int DATA_W = 8,
  localparam int SEL_W  = $clog2(NUM_CH)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     mode,
  input  logic [SEL_W-1:0]         sel,
  input  logic [NUM_CH*DATA_W-1:0] in_data,
  input  logic [NUM_CH-1:0]        in_valid,
  output logic [NUM_CH-1:0]        in_ready,
  output logic [DATA_W-1:0]        out_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [SEL_W-1:0]         out_ch
);

  logic [DATA_W-1:0] out_data_q, out_data_d;
  logic              out_valid_q, out_valid_d;
  logic [SEL_W-1:0]  out_ch_q, out_ch_d;
  logic [SEL_W-1:0]  rr_ptr_q, rr_ptr_d;

  logic              load_en;
  logic              rr_gnt_valid;
  logic [SEL_W-1:0]  rr_gnt_idx;
  logic              cand_valid;
  logic [SEL_W-1:0]  cand;
  logic [DATA_W-1:0] cand_data;
  logic              fire;

  rr_arbiter_nch #(.NUM_CH(NUM_CH)) u_arb (
    .req       (in_valid),
    .ptr       (rr_ptr_q),
    .gnt_valid (rr_gnt_valid),
    .gnt_idx   (rr_gnt_idx)
  );

  // Candidate selection, handshake and next-state for the output register.
  always_comb begin
    load_en = !out_valid_q || out_ready;

    if (mode == MODE_RR) begin
      cand_valid = rr_gnt_valid;
      cand       = rr_gnt_idx;
    end else begin
      cand_valid = (32'(sel) < NUM_CH);
      cand       = sel;
    end

    // Shift rather than index so an out-of-range sel never selects past the bus.
    cand_data = DATA_W'(in_data >> slice_lo(32'(cand), DATA_W));

    in_ready = (cand_valid && load_en && !rst) ? (NUM_CH'(1) << cand) : '0;
    fire     = cand_valid && in_valid[cand] && load_en && !rst;

    out_data_d  = out_data_q;
    out_ch_d    = out_ch_q;
    out_valid_d = out_valid_q;
    rr_ptr_d    = rr_ptr_q;

    if (fire) begin
      out_data_d  = cand_data;
      out_ch_d    = cand;
      out_valid_d = 1'b1;
      if (mode == MODE_RR) begin
        rr_ptr_d = (32'(cand) == NUM_CH - 1) ? '0 : cand + SEL_W'(1);
      end
    end else if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  // Output register and round-robin pointer, cleared asynchronously.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      out_ch_q    <= '0;
      rr_ptr_q    <= '0;
    end else begin
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      out_ch_q    <= out_ch_d;
      rr_ptr_q    <= rr_ptr_d;
    end
  end

  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign out_ch    = out_ch_q;

endmodule

// File: tb/tb_stream_mux_nch.sv
// Directed self-checking bench for stream_mux_nch (4-channel and 3-channel instances).
module tb_stream_mux_nch;

  logic clk = 1'b0;
  logic rst;

  // 4-channel instance
  logic        mode4;
  logic [1:0]  sel4;
  logic [31:0] in_data4;
  logic [3:0]  in_valid4;
  logic [3:0]  in_ready4;
  logic [7:0]  out_data4;
  logic        out_valid4;
  logic        out_ready4;
  logic [1:0]  out_ch4;

  // 3-channel instance
  logic        mode3;
  logic [1:0]  sel3;
  logic [23:0] in_data3;
  logic [2:0]  in_valid3;
  logic [2:0]  in_ready3;
  logic [7:0]  out_data3;
  logic        out_valid3;
  logic        out_ready3;
  logic [1:0]  out_ch3;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  stream_mux_nch #(.NUM_CH(4), .DATA_W(8)) dut4 (
    .clk(clk), .rst(rst), .mode(mode4), .sel(sel4), .in_data(in_data4),
    .in_valid(in_valid4), .in_ready(in_ready4), .out_data(out_data4),
    .out_valid(out_valid4), .out_ready(out_ready4), .out_ch(out_ch4)
  );

  stream_mux_nch #(.NUM_CH(3), .DATA_W(8)) dut3 (
    .clk(clk), .rst(rst), .mode(mode3), .sel(sel3), .in_data(in_data3),
    .in_valid(in_valid3), .in_ready(in_ready3), .out_data(out_data3),
    .out_valid(out_valid3), .out_ready(out_ready3), .out_ch(out_ch3)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    mode4 = 1'b0; sel4 = 2'd0; in_data4 = 32'h44332211; in_valid4 = 4'b1111; out_ready4 = 1'b1;
    mode3 = 1'b0; sel3 = 2'd0; in_data3 = 24'h0; in_valid3 = 3'b000; out_ready3 = 1'b1;
    #2;
    checks++; if (out_valid4 !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", out_valid4); end
    checks++; if (out_data4 !== 8'h00) begin errors++; $display("FAIL reset_data got %h exp 00", out_data4); end
    checks++; if (out_ch4 !== 2'd0) begin errors++; $display("FAIL reset_ch got %0d exp 0", out_ch4); end
    checks++; if (in_ready4 !== 4'b0000) begin errors++; $display("FAIL reset_in_ready got %b exp 0000", in_ready4); end
    tick();
    tick();
    rst = 1'b0;
    in_valid4 = 4'b0000;
    tick();
  endtask

  task automatic test_sel();
    logic [7:0] exp_d;
    mode4 = 1'b0; sel4 = 2'd2; in_valid4 = 4'b1111; in_data4 = 32'h44A52211; out_ready4 = 1'b1;
    #1;
    checks++; if (in_ready4 !== 4'b0100) begin errors++; $display("FAIL sel_in_ready got %b exp 0100", in_ready4); end
    tick();
    checks++; if (out_valid4 !== 1'b1) begin errors++; $display("FAIL sel_valid got %b exp 1", out_valid4); end
    checks++; if (out_data4 !== 8'hA5) begin errors++; $display("FAIL sel_data got %h exp a5", out_data4); end
    checks++; if (out_ch4 !== 2'd2) begin errors++; $display("FAIL sel_ch got %0d exp 2", out_ch4); end
    for (int i = 0; i < 4; i++) begin
      exp_d = 8'h50 + 8'(i);
      in_data4[16 +: 8] = exp_d;
      #1;
      checks++; if (in_ready4 !== 4'b0100) begin errors++; $display("FAIL sel_stream_ready[%0d] got %b exp 0100", i, in_ready4); end
      tick();
      checks++; if (out_valid4 !== 1'b1 || out_data4 !== exp_d || out_ch4 !== 2'd2)
        begin errors++; $display("FAIL sel_stream[%0d] got v=%b d=%h ch=%0d exp v=1 d=%h ch=2", i, out_valid4, out_data4, out_ch4, exp_d); end
    end
  endtask

  task automatic test_backpressure();
    sel4 = 2'd1; in_data4[8 +: 8] = 8'h3C;
    tick();
    checks++; if (out_data4 !== 8'h3C || out_ch4 !== 2'd1) begin errors++; $display("FAIL bp_load got d=%h ch=%0d exp d=3c ch=1", out_data4, out_ch4); end
    out_ready4 = 1'b0;
    for (int i = 0; i < 5; i++) begin
      sel4 = 2'(i);
      in_data4 = {4{8'hE0 + 8'(i)}};
      #1;
      checks++; if (in_ready4 !== 4'b0000) begin errors++; $display("FAIL bp_in_ready[%0d] got %b exp 0000", i, in_ready4); end
      tick();
      checks++; if (out_valid4 !== 1'b1 || out_data4 !== 8'h3C || out_ch4 !== 2'd1)
        begin errors++; $display("FAIL bp_hold[%0d] got v=%b d=%h ch=%0d exp v=1 d=3c ch=1", i, out_valid4, out_data4, out_ch4); end
    end
    out_ready4 = 1'b1; sel4 = 2'd3; in_data4[24 +: 8] = 8'h77;
    #1;
    checks++; if (in_ready4 !== 4'b1000) begin errors++; $display("FAIL bp_release_ready got %b exp 1000", in_ready4); end
    tick();
    checks++; if (out_valid4 !== 1'b1 || out_data4 !== 8'h77 || out_ch4 !== 2'd3)
      begin errors++; $display("FAIL bp_reload got v=%b d=%h ch=%0d exp v=1 d=77 ch=3", out_valid4, out_data4, out_ch4); end
    in_valid4 = 4'b0000;
    tick();
    checks++; if (out_valid4 !== 1'b0 || out_data4 !== 8'h77 || out_ch4 !== 2'd3)
      begin errors++; $display("FAIL bp_drain got v=%b d=%h ch=%0d exp v=0 d=77 ch=3", out_valid4, out_data4, out_ch4); end
  endtask

  task automatic test_rr_fairness();
    logic [1:0] exp_ch;
    logic [7:0] exp_d;
    mode4 = 1'b1; in_valid4 = 4'b1111; in_data4 = 32'h40302010; out_ready4 = 1'b1;
    for (int i = 0; i < 8; i++) begin
      exp_ch = 2'(i % 4);
      exp_d  = 8'h10 * (8'(i % 4) + 8'd1);
      tick();
      checks++; if (out_valid4 !== 1'b1 || out_ch4 !== exp_ch || out_data4 !== exp_d)
        begin errors++; $display("FAIL rr_fair[%0d] got v=%b ch=%0d d=%h exp v=1 ch=%0d d=%h", i, out_valid4, out_ch4, out_data4, exp_ch, exp_d); end
    end
  endtask

  task automatic test_rr_sparse();
    logic [1:0] exp_seq [4] = '{2'd0, 2'd3, 2'd0, 2'd3};
    in_valid4 = 4'b1001;
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++; if (out_valid4 !== 1'b1 || out_ch4 !== exp_seq[i])
        begin errors++; $display("FAIL rr_sparse[%0d] got v=%b ch=%0d exp v=1 ch=%0d", i, out_valid4, out_ch4, exp_seq[i]); end
    end
    in_valid4 = 4'b0100;
    #1;
    checks++; if (in_ready4 !== 4'b0100) begin errors++; $display("FAIL rr_single_ready got %b exp 0100", in_ready4); end
    tick();
    checks++; if (out_ch4 !== 2'd2 || out_data4 !== 8'h30) begin errors++; $display("FAIL rr_single got ch=%0d d=%h exp ch=2 d=30", out_ch4, out_data4); end
    in_valid4 = 4'b1111;
    #1;
    checks++; if (in_ready4 !== 4'b1000) begin errors++; $display("FAIL rr_ptr3_ready got %b exp 1000", in_ready4); end
    tick();
    checks++; if (out_ch4 !== 2'd3) begin errors++; $display("FAIL rr_ptr3 got ch=%0d exp 3", out_ch4); end
    in_valid4 = 4'b0000;
    #1;
    checks++; if (in_ready4 !== 4'b0000) begin errors++; $display("FAIL rr_idle_ready got %b exp 0000", in_ready4); end
    tick();
    checks++; if (out_valid4 !== 1'b0) begin errors++; $display("FAIL rr_idle_valid got %b exp 0", out_valid4); end
  endtask

  task automatic test_reset_midstream();
    in_valid4 = 4'b1111;
    tick();
    checks++; if (out_valid4 !== 1'b1 || out_ch4 !== 2'd0) begin errors++; $display("FAIL mid_pre got v=%b ch=%0d exp v=1 ch=0", out_valid4, out_ch4); end
    in_valid4 = 4'b1111; out_ready4 = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    checks++; if (out_valid4 !== 1'b0 || out_ch4 !== 2'd0 || out_data4 !== 8'h00)
      begin errors++; $display("FAIL mid_rst got v=%b ch=%0d d=%h exp v=0 ch=0 d=00", out_valid4, out_ch4, out_data4); end
    out_ready4 = 1'b1;
    #1;
    checks++; if (in_ready4 !== 4'b0000) begin errors++; $display("FAIL mid_rst_ready got %b exp 0000", in_ready4); end
    tick();
    checks++; if (out_valid4 !== 1'b0) begin errors++; $display("FAIL mid_rst_hold got %b exp 0", out_valid4); end
    rst = 1'b0;
    #1;
    checks++; if (in_ready4 !== 4'b0001) begin errors++; $display("FAIL mid_first_ready got %b exp 0001", in_ready4); end
    tick();
    checks++; if (out_valid4 !== 1'b1 || out_ch4 !== 2'd0 || out_data4 !== 8'h10)
      begin errors++; $display("FAIL mid_first got v=%b ch=%0d d=%h exp v=1 ch=0 d=10", out_valid4, out_ch4, out_data4); end
    in_valid4 = 4'b0000; mode4 = 1'b0;
    tick();
  endtask

  task automatic test_invalid_sel_and_switch();
    mode3 = 1'b0; sel3 = 2'd3; in_valid3 = 3'b111; in_data3 = 24'h332211; out_ready3 = 1'b1;
    #1;
    checks++; if (in_ready3 !== 3'b000) begin errors++; $display("FAIL inv_ready got %b exp 000", in_ready3); end
    tick();
    tick();
    checks++; if (out_valid3 !== 1'b0) begin errors++; $display("FAIL inv_valid got %b exp 0", out_valid3); end
    mode3 = 1'b1;
    #1;
    checks++; if (in_ready3 !== 3'b001) begin errors++; $display("FAIL sw_rr_ready got %b exp 001", in_ready3); end
    tick();
    checks++; if (out_ch3 !== 2'd0 || out_data3 !== 8'h11) begin errors++; $display("FAIL sw_rr got ch=%0d d=%h exp ch=0 d=11", out_ch3, out_data3); end
    mode3 = 1'b0; sel3 = 2'd2;
    tick();
    checks++; if (out_ch3 !== 2'd2 || out_data3 !== 8'h33) begin errors++; $display("FAIL sw_sel got ch=%0d d=%h exp ch=2 d=33", out_ch3, out_data3); end
    out_ready3 = 1'b0; mode3 = 1'b1; in_data3 = 24'hCCBBAA;
    #1;
    checks++; if (in_ready3 !== 3'b000) begin errors++; $display("FAIL sw_stall_ready got %b exp 000", in_ready3); end
    for (int i = 0; i < 2; i++) begin
      tick();
      checks++; if (out_valid3 !== 1'b1 || out_ch3 !== 2'd2 || out_data3 !== 8'h33)
        begin errors++; $display("FAIL sw_hold[%0d] got v=%b ch=%0d d=%h exp v=1 ch=2 d=33", i, out_valid3, out_ch3, out_data3); end
    end
    out_ready3 = 1'b1;
    #1;
    checks++; if (in_ready3 !== 3'b010) begin errors++; $display("FAIL sw_ptr_ready got %b exp 010", in_ready3); end
    tick();
    checks++; if (out_ch3 !== 2'd1 || out_data3 !== 8'hBB) begin errors++; $display("FAIL sw_ptr got ch=%0d d=%h exp ch=1 d=bb", out_ch3, out_data3); end
    in_valid3 = 3'b000;
    tick();
  endtask

  initial begin
    test_reset();
    test_sel();
    test_backpressure();
    test_rr_fairness();
    test_rr_sparse();
    test_reset_midstream();
    test_invalid_sel_and_switch();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/stream_mux_nch.md
Name: stream_mux_nch

Overview:
- Parametrised N-channel, W-bit multiplexer with valid/ready handshakes and one registered output stage.
- Two selection modes:
  - Externally selected: the sel port chooses the channel.
  - Internal round-robin arbitration across all requesting channels.
- Reports the source channel of each output beat.
- Sits between multiple stream producers and a single downstream consumer in the datapath.

Parameters:
- NUM_CH, 4, number of input channels (2..16).
- DATA_W, 8, data width per channel in bits.
- SEL_W, $clog2(NUM_CH), derived localparam; width of sel and out_ch.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-high reset.
- mode  input  1  0 = MODE_SEL (external select), 1 = MODE_RR (round-robin).
- sel  input  SEL_W  channel index, used only in MODE_SEL.
- in_data  input  NUM_CH*DATA_W  packed channel data; channel k occupies bits [k*DATA_W +: DATA_W].
- in_valid  input  NUM_CH  per-channel valid.
- in_ready  output  NUM_CH  per-channel ready; at most one bit high per cycle.
- out_data  output  DATA_W  registered output data.
- out_valid  output  1  registered output valid.
- out_ready  input  1  downstream ready.
- out_ch  output  SEL_W  channel index that produced the current out_data.

Behaviour:
- Reset (async, rst=1):
  - out_valid=0, out_data=0, out_ch=0, rr_ptr=0.
  - in_ready is combinational and is all zeros while rst=1.
- Load enable: load_en = !out_valid || out_ready. The output register accepts a new beat only when load_en=1.
- Candidate channel:
  - MODE_SEL: cand = sel. If sel >= NUM_CH, there is no candidate and all in_ready are 0.
  - MODE_RR: cand = first k with in_valid[k]=1, searching rr_ptr, rr_ptr+1, ..., wrapping mod NUM_CH. No candidate if in_valid is all zero.
- in_ready[cand] = load_en; all other in_ready bits are 0.
  - In MODE_RR, in_ready depends combinationally on in_valid. This is permitted for this block; producers must not make in_valid depend on in_ready.
- Transfer: fires when in_valid[cand] && in_ready[cand]. On the next edge: out_data <= cand's data, out_ch <= cand, out_valid <= 1.
- Output drain: if out_valid && out_ready and no transfer fires, out_valid <= 0. out_data and out_ch hold their last values.
- Simultaneous drain and load (out_valid=1, out_ready=1, transfer fires): the register is replaced in the same edge. This gives full throughput of 1 beat/cycle.
- Latency: 1 cycle from input acceptance to out_valid.
- Stall: while out_valid=1 && out_ready=0, out_data and out_ch are held stable. No input is accepted.
- Round-robin pointer:
  - On each transfer in MODE_RR: rr_ptr <= (cand+1) mod NUM_CH.
  - No update in MODE_SEL or on idle cycles.
  - Wrap: cand=NUM_CH-1 → rr_ptr=0.
- Fairness (MODE_RR): with all channels continuously valid and out_ready=1, grants cycle 0,1,..,NUM_CH-1,0,...
- Mode or sel change:
  - Affects only candidate selection in the same cycle.
  - An already-registered output beat is never altered.
  - rr_ptr is retained across mode switches.
- Reset mid-operation: a pending output beat is discarded (out_valid=0 immediately on rst assertion). No in_ready pulse during reset.
- No data is ever duplicated or dropped: every accepted input beat appears exactly once on the output with the correct out_ch.

Decomposition:
- Package stream_mux_pkg holds:
  - MODE_SEL=1'b0 and MODE_RR=1'b1.
  - A function for the packed-slice index.
- Sub-module rr_arbiter_nch (parameter NUM_CH):
  - Inputs: req[NUM_CH], ptr[SEL_W].
  - Outputs: gnt_valid, gnt_idx[SEL_W].
  - Purely combinational rotate-priority search.
- stream_mux_nch owns:
  - rr_ptr.
  - The output register.
  - The handshake logic.

Test Plan:
- Reset: assert rst mid-stream with out_valid=1 → out_valid=0, out_ch=0, in_ready=0 immediately. After release, the first RR grant goes to channel 0.
- MODE_SEL, NUM_CH=4, sel=2, in_valid=4'b1111, ch2 data=8'hA5, out_ready=1:
  - in_ready=4'b0100.
  - Next cycle out_data=8'hA5, out_ch=2.
  - Then 1 beat/cycle sustained.
- MODE_SEL backpressure: load ch1=8'h3C, then hold out_ready=0 for 5 cycles while changing sel and data → out_data=8'h3C, out_ch=1 stable, in_ready=0. On out_ready=1, the next beat is loaded in the same edge.
- MODE_RR fairness: all 4 valid, out_ready=1 for 8 cycles → out_ch sequence 0,1,2,3,0,1,2,3.
- MODE_RR sparse requests with wrap: in_valid=4'b1001 from rr_ptr=0 → grants 0,3,0,3. With in_valid=4'b0100 only → ch2 granted, rr_ptr=3.
- Invalid select with NUM_CH=3: sel=3 → in_ready=3'b000, out_valid stays 0. Mode switch to MODE_RR mid-stream preserves the held beat and the rr_ptr value.
